tt_ctrl_sel: RTL
================

// Module: tt_ctrl_sel
// PURPOSE
//  Upstream selection front-end of tt_ctrl: conditions the three control pads
//  (sel_rst_n, sel_inc, ena) and drives the spine address and enable that the
//  branch muxes (tt_mux) decode. Pads are synchronized and sel_inc edges are
//  counted into a {branch, um} address. The enable is released only after the
//  address has been stable for a settle window, so no user module sees a
//  glitched select.
// PARAMETERS
//  N_BRANCH     24  number of branches (valid branch address 0..N_BRANCH-1)
//  N_UM         16  user modules per branch (power of 2)
//  SYNC_STAGES  2   flops per pad synchronizer (>=2)
//  SETTLE       4   stable cycles required before spine_ena asserts (>=1)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  synchronous active-low reset
//  pad_sel_rst_n  in   1  async pad: low clears the selection
//  pad_sel_inc    in   1  async pad: each rising edge advances the selection
//  pad_ena        in   1  async pad: request enable of the selected module
//  spine_addr     out  9  {branch[4:0], um[3:0]} to the spine
//  spine_ena      out  1  enable of the addressed module
//  sel_busy       out  1  high while in SETTLE
//  sel_wrap       out  1  1-cycle pulse when the address wraps to 0 by increment
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all sync flops 0 (sel_rst_n sync flops 1),
//    spine_addr=0, spine_ena=0, sel_busy=0, sel_wrap=0, state=IDLE, settle cnt=0.
//  - Each pad passes through SYNC_STAGES flops. inc_edge = sync_inc & ~inc_d,
//    with inc_d one extra flop. The pad-to-address update takes SYNC_STAGES+1
//    clk edges after the first edge that samples the pad high.
//  - Address arithmetic: the um field increments first. When um=N_UM-1, um goes
//    to 0 and branch increments. When branch=N_BRANCH-1 and um=N_UM-1, the
//    address goes to 0 and sel_wrap pulses in the same cycle the address updates.
//    Branch values >=N_BRANCH are never produced.
//  - The synchronized sel_rst_n low sets the address to 0 every cycle it is low.
//    inc_edge is ignored while it is low, and a simultaneous inc_edge loses.
//  - FSM:
//    IDLE:   spine_ena=0. On inc_edge or sel_rst low, go to SETTLE.
//            Otherwise, go to ACTIVE when sync_ena=1.
//    SETTLE: spine_ena=0, sel_busy=1. The counter loads 0 on entry and on any
//            further inc_edge or sel_rst low. When the count reaches SETTLE-1
//            with no such event, go to ACTIVE if sync_ena=1, else IDLE.
//    ACTIVE: spine_ena=1. On inc_edge or sel_rst low, go to SETTLE and deassert
//            spine_ena in that same registered update, i.e. before the new
//            address is seen. On sync_ena=0, go to IDLE.
//  - spine_ena and spine_addr are registered outputs. In ACTIVE, spine_addr never
//    changes while spine_ena=1 (no glitch window).
//  - Minimum SETTLE dwell is SETTLE cycles. Back-to-back inc edges restart it.
//  - Priority: rst_n > sel_rst low > inc_edge > sync_ena.
// TESTING
//  1. Release rst_n, pads idle (sel_rst_n=1, inc=0, ena=0): 20 cycles, all
//     outputs stay 0 and state stays IDLE.
//  2. Five inc pulses (4 cycles high, 4 low), ena=1 -> spine_addr=0x005. The
//     first update lands 3 clk after the pad rises. spine_ena=1 exactly SETTLE=4
//     cycles after the last address change.
//  3. 16 incs from 0 -> spine_addr=0x010 (branch 1, um 0). 383 incs from 0 ->
//     0x17F. One more inc -> 0x000 with a single-cycle sel_wrap.
//  4. In ACTIVE at 0x0A3, pulse inc -> spine_ena=0 on the same edge that
//     sel_busy=1, with spine_addr still 0x0A3 on that edge. Then addr=0x0A4 and
//     spine_ena returns after the settle window.
//  5. Hold sel_rst_n low while pulsing inc -> addr stays 0 and sel_busy stays 1.
//     Release -> ACTIVE after SETTLE cycles with addr=0x000.
//  6. Assert rst_n=0 mid-SETTLE at addr 0x042 -> next edge: addr=0, ena=0,
//     busy=0, IDLE. Also drop pad_ena in ACTIVE -> spine_ena=0 3 clk later.

Source files
------------

// File: rtl/tt_ctrl_sel_if.sv
// Pad inputs and spine outputs of the selection front-end.
interface tt_ctrl_sel_if #(
  parameter int ADDR_W = 9
);
  logic              pad_sel_rst_n;
  logic              pad_sel_inc;
  logic              pad_ena;
  logic [ADDR_W-1:0] spine_addr;
  logic              spine_ena;
  logic              sel_busy;
  logic              sel_wrap;

  // Pad driver side (board / testbench).
  modport master (
    output pad_sel_rst_n, pad_sel_inc, pad_ena,
    input  spine_addr, spine_ena, sel_busy, sel_wrap
  );

  // Selection logic side.
  modport slave (
    input  pad_sel_rst_n, pad_sel_inc, pad_ena,
    output spine_addr, spine_ena, sel_busy, sel_wrap
  );
endinterface

// File: rtl/tt_ctrl_sel.sv
// Selection front-end: synchronizes the control pads, counts sel_inc edges
// into a {branch, um} address and only enables the spine once the address
// has been stable for a settle window.
module tt_ctrl_sel #(
  parameter int N_BRANCH    = 24,
  parameter int N_UM        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_ctrl_sel_if.slave  sif
);
  localparam int BR_W = $clog2(N_BRANCH);
  localparam int UM_W = $clog2(N_UM);
  localparam int AW   = BR_W + UM_W;
  localparam int CW   = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [BR_W-1:0] BR_LAST  = BR_W'(N_BRANCH - 1);
  localparam logic [UM_W-1:0] UM_LAST  = UM_W'(N_UM - 1);

  typedef enum logic [1:0] {IDLE, SETTLE_ST, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
  logic [SYNC_STAGES-1:0] ena_sync_q, ena_sync_d;
  logic                   inc_dly_q, inc_dly_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [AW-1:0]          spine_addr_q, spine_addr_d;
  logic                   spine_ena_q, spine_ena_d;
  logic                   sel_busy_q, sel_busy_d;
  logic                   sel_wrap_q, sel_wrap_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_t                 state_q, state_d;

  logic sel_rst_lo, inc_edge, sync_ena, ev, pend;
  logic [BR_W-1:0] br;
  logic [UM_W-1:0] um;

  assign sel_rst_lo = ~rst_sync_q[SYNC_STAGES-1];
  assign inc_edge   = inc_sync_q[SYNC_STAGES-1] & ~inc_dly_q;
  assign sync_ena   = ena_sync_q[SYNC_STAGES-1];
  // Any event that disturbs the address restarts the settle window.
  assign ev         = sel_rst_lo | inc_edge;
  // Spine address still catching up with the counter after leaving ACTIVE.
  assign pend       = (spine_addr_q != addr_q);
  assign br         = addr_q[AW-1:UM_W];
  assign um         = addr_q[UM_W-1:0];

  // Pad synchronizer shift chains and the inc edge-detect delay flop.
  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], sif.pad_sel_rst_n};
    inc_sync_d = {inc_sync_q[SYNC_STAGES-2:0], sif.pad_sel_inc};
    ena_sync_d = {ena_sync_q[SYNC_STAGES-2:0], sif.pad_ena};
    inc_dly_d  = inc_sync_q[SYNC_STAGES-1];
  end

  // Address counter: um first, then branch; sel_rst wins over inc.
  always_comb begin
    addr_d     = addr_q;
    sel_wrap_d = 1'b0;
    if (sel_rst_lo) begin
      addr_d = '0;
    end else if (inc_edge) begin
      if (um == UM_LAST) begin
        if (br == BR_LAST) begin
          addr_d     = '0;
          sel_wrap_d = 1'b1;
        end else begin
          addr_d = {br + BR_W'(1), {UM_W{1'b0}}};
        end
      end else begin
        addr_d = {br, um + UM_W'(1)};
      end
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (ev) state_d = SETTLE_ST;
                 else if (sync_ena) state_d = ACTIVE;
      SETTLE_ST: if (!ev && !pend && cnt_q == CNT_LAST)
                   state_d = sync_ena ? ACTIVE : IDLE;
      ACTIVE:    if (ev) state_d = SETTLE_ST;
                 else if (!sync_ena) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs and settle counter; spine address is frozen in ACTIVE
  // so it only moves once spine_ena has already dropped.
  always_comb begin
    spine_ena_d  = (state_d == ACTIVE);
    sel_busy_d   = (state_d == SETTLE_ST);
    spine_addr_d = (state_q == ACTIVE) ? spine_addr_q : addr_d;
    cnt_d        = '0;
    if (state_q == SETTLE_ST && !ev && !pend) cnt_d = cnt_q + CW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_sync_q   <= '1;
      inc_sync_q   <= '0;
      ena_sync_q   <= '0;
      inc_dly_q    <= 1'b0;
      addr_q       <= '0;
      spine_addr_q <= '0;
      spine_ena_q  <= 1'b0;
      sel_busy_q   <= 1'b0;
      sel_wrap_q   <= 1'b0;
      cnt_q        <= '0;
      state_q      <= IDLE;
    end else begin
      rst_sync_q   <= rst_sync_d;
      inc_sync_q   <= inc_sync_d;
      ena_sync_q   <= ena_sync_d;
      inc_dly_q    <= inc_dly_d;
      addr_q       <= addr_d;
      spine_addr_q <= spine_addr_d;
      spine_ena_q  <= spine_ena_d;
      sel_busy_q   <= sel_busy_d;
      sel_wrap_q   <= sel_wrap_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
    end
  end

  assign sif.spine_addr = spine_addr_q;
  assign sif.spine_ena  = spine_ena_q;
  assign sif.sel_busy   = sel_busy_q;
  assign sif.sel_wrap   = sel_wrap_q;
endmodule
